// File: rtl/fpmul_pkg.sv
// Shared types and constants for the parameterised floating-point multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpmul_pkg;

  // Widest format the constant helpers below can build.
  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULT,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  // Bit positions inside flags = {invalid, overflow, underflow, inexact}.
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Unsigned infinity: exponent all ones, fraction zero, sign clear.
  function automatic logic [MAX_W-1:0] inf_mag(input int exp_w, input int frac_w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) begin
      r[frac_w+i] = 1'b1;
    end
    return r;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [MAX_W-1:0] canon_nan(input int exp_w, input int frac_w);
    logic [MAX_W-1:0] r;
    r = inf_mag(exp_w, frac_w);
    r[frac_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fpmul_mant_iter.sv
// Iterative shift-add unsigned multiplier, RADIX multiplier bits retired per step.
// Latency: one load cycle plus ceil(bits/RADIX) step cycles; product is exact once the multiplier is exhausted.
// Backpressure: none; the controller owns load/step sequencing.
// Ports: clk; load captures mcand/mplier and clears the accumulator; step retires one digit;
//        product is the running accumulator (2*N bits).
module fpmul_mant_iter #(
  parameter int N     = 24,
  parameter int RADIX = 4
) (
  input  logic           clk,
  input  logic           load,
  input  logic           step,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] product
);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand_sh;
  logic [N-1:0]   mplier_q;
  logic [2*N-1:0] partial;

  // The multiplicand is shifted left instead of shifting the accumulator right, so the
  // accumulator holds the exact product after any number of steps. Reduced-precision
  // operands are right-justified and simply need fewer steps.
  assign partial = mcand_sh * {{(2*N-RADIX){1'b0}}, mplier_q[RADIX-1:0]};

  always_ff @(posedge clk) begin
    if (load) begin
      acc      <= '0;
      mcand_sh <= {{N{1'b0}}, mcand};
      mplier_q <= mplier;
    end else if (step) begin
      acc      <= acc + partial;
      mcand_sh <= mcand_sh << RADIX;
      mplier_q <= mplier_q >> RADIX;
    end
  end

  assign product = acc;

endmodule

// File: rtl/fpmul_param.sv
// Multi-cycle IEEE-style multiplier with full or reduced precision selectable per operation.
// Latency: done asserts M+3 edges after the edge that accepts start (M = mantissa steps for the mode).
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
// Ports: Clock, reset (sync, active low); start/mode/A/B request; Product/flags registered
//        result held until the next done; done one-cycle pulse; busy high outside IDLE.
module fpmul_param
  import fpmul_pkg::*;
#(
  parameter int EXP_W    = 8,
  parameter int FRAC_W   = 23,
  parameter int FRAC_R_W = 7,
  parameter int RADIX    = 4
) (
  input  logic                    Clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [EXP_W+FRAC_W:0]   A,
  input  logic [EXP_W+FRAC_W:0]   B,
  output logic [EXP_W+FRAC_W:0]   Product,
  output logic                    done,
  output logic                    busy,
  output logic [3:0]              flags
);

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int N      = FRAC_W + 1;
  localparam int PW     = 2 * N;
  localparam int D      = FRAC_W - FRAC_R_W;
  localparam int EW     = EXP_W + 2;
  localparam int M_FULL = ceil_div(FRAC_W + 1, RADIX);
  localparam int M_RED  = ceil_div(FRAC_R_W + 1, RADIX);
  localparam int CW     = $clog2(M_FULL + 1);

  localparam logic [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]  RED_MASK = {W{1'b1}} << D;
  localparam logic [W-1:0]  NAN_VAL  = W'(canon_nan(EXP_W, FRAC_W));
  localparam logic [W-1:0]  INF_VAL  = W'(inf_mag(EXP_W, FRAC_W));

  // Normalised product keeps its hidden bit at PW-1; these mark the result LSB.
  localparam logic [PW-1:0] KEEP_F = {PW{1'b1}} << (FRAC_W + 1);
  localparam logic [PW-1:0] KEEP_R = {PW{1'b1}} << (FRAC_W + 1 + D);
  localparam logic [PW-1:0] INC_F  = PW'(1) << (FRAC_W + 1);
  localparam logic [PW-1:0] INC_R  = PW'(1) << (FRAC_W + 1 + D);

  state_t state, state_nxt;

  logic [W-1:0]  a_q, b_q;
  logic          mode_q;
  logic [CW-1:0] cnt;
  logic          sign_q;
  logic [EW-1:0] exp_q;
  logic          spec_q;
  logic [W-1:0]  spec_res_q;
  logic [3:0]    spec_flg_q;
  logic [PW-1:0] pn_q;
  logic [PW-1:0] prod;

  // ---------------------------------------------------------------- control
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = ST_MULT;
      ST_MULT:   if (cnt == (mode_q ? CW'(M_FULL - 1) : CW'(M_RED - 1))) state_nxt = ST_NORM;
      ST_NORM:   state_nxt = ST_ROUND;
      ST_ROUND:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign done = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------- unpack
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_res;
  logic [N-1:0]      ma, mb;

  always_comb begin
    ea     = a_q[W-2:FRAC_W];
    eb     = b_q[W-2:FRAC_W];
    fa     = a_q[FRAC_W-1:0];
    fb     = b_q[FRAC_W-1:0];
    s_res  = a_q[W-1] ^ b_q[W-1];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    // Reduced mantissas are right-justified so the multiplier finishes in M_RED steps.
    ma     = mode_q ? {1'b1, fa} : ({1'b1, fa} >> D);
    mb     = mode_q ? {1'b1, fb} : ({1'b1, fb} >> D);
  end

  fpmul_mant_iter #(
    .N     (N),
    .RADIX (RADIX)
  ) u_mant (
    .clk     (Clock),
    .load    (state == ST_UNPACK),
    .step    (state == ST_MULT),
    .mcand   (ma),
    .mplier  (mb),
    .product (prod)
  );

  // ---------------------------------------------------------------- normalise
  logic [PW-1:0] prod_al;
  logic          nrm_carry;

  always_comb begin
    // Reduced product sits 2*D bits low; realign so both modes share one layout.
    prod_al   = mode_q ? prod : (prod << (2 * D));
    nrm_carry = prod_al[PW-1];
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge Clock) begin
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_q    <= mode ? A : (A & RED_MASK);
          b_q    <= mode ? B : (B & RED_MASK);
          mode_q <= mode;
        end
      end
      ST_UNPACK: begin
        cnt        <= '0;
        sign_q     <= s_res;
        exp_q      <= {2'b00, ea} + {2'b00, eb} - BIAS;
        spec_q     <= a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        spec_flg_q <= '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
          spec_res_q              <= NAN_VAL;
          spec_flg_q[FLG_INVALID] <= 1'b1;
        end else if (a_inf || b_inf) begin
          spec_res_q <= {s_res, INF_VAL[W-2:0]};
        end else begin
          spec_res_q <= {s_res, {(W-1){1'b0}}};
        end
      end
      ST_MULT: cnt <= cnt + 1'b1;
      ST_NORM: begin
        pn_q  <= nrm_carry ? prod_al : (prod_al << 1);
        exp_q <= exp_q + EW'(nrm_carry);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- round
  logic [PW-1:0] keep, inc, low;
  logic          guard, rest, lsb, rnd_up;
  logic [PW:0]   sum;
  logic [EW-1:0] exp_r;
  logic [W-1:0]  res;
  logic [3:0]    flg;

  always_comb begin
    keep   = mode_q ? KEEP_F : KEEP_R;
    inc    = mode_q ? INC_F  : INC_R;
    low    = pn_q & ~keep;
    guard  = |(low & (inc >> 1));
    rest   = |(low & ~(inc >> 1));
    lsb    = |(pn_q & inc);
    rnd_up = guard & (lsb | rest);
    sum    = {1'b0, pn_q & keep} + (rnd_up ? {1'b0, inc} : '0);
    // A rounding carry leaves an all-zero fraction, so only the exponent needs fixing.
    exp_r  = exp_q + EW'(sum[PW]);
    res    = {sign_q, exp_r[EXP_W-1:0], sum[PW-2:FRAC_W+1]};
    flg    = '0;
    flg[FLG_INEXACT] = guard | rest;
    if (spec_q) begin
      res = spec_res_q;
      flg = spec_flg_q;
    end else if (!exp_r[EW-1] && (exp_r >= EMAX)) begin
      res = {sign_q, INF_VAL[W-2:0]};
      flg[FLG_OVERFLOW] = 1'b1;
      flg[FLG_INEXACT]  = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      res = {sign_q, {(W-1){1'b0}}};
      flg[FLG_UNDERFLOW] = 1'b1;
      flg[FLG_INEXACT]   = 1'b1;
    end
  end

  logic unused_sum_bits;
  assign unused_sum_bits = ^{sum[PW-1], sum[FRAC_W:0]};

  // ---------------------------------------------------------------- state / outputs
  always_ff @(posedge Clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      Product <= '0;
      flags   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ROUND) begin
        Product <= res;
        flags   <= flg;
      end
    end
  end

endmodule
